prog_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the instruction memory of the single-cycle RISC-V core. It accepts a byte stream (length header followed by little-endian 32-bit instruction words) over a valid/ready handshake. It assembles each word and writes it into instruction memory through a dedicated write port. It holds the core in reset until the image is fully loaded.

---
 rtl/loader_pkg.sv | 21 ++
 rtl/word_assembler.sv | 43 ++++
 rtl/prog_loader.sv | 130 +++++++++++++
 tb/tb_prog_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared state encoding and constants for the program loader.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN0  = 3'd0,
        ST_LEN1  = 3'd1,
        ST_DATA  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int c_idx_width = 2;
    localparam int c_hdr_bytes = 2;

endpackage
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : word_assembler
// Description : Collects four little-endian bytes into one 32-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        word_last
);

    logic [c_idx_width-1:0] r_idx;
    logic [31:0]            r_word;

    // word_out already contains the incoming byte, so the 4th byte is usable on its own edge
    always_comb begin
        word_out = r_word;
        if (byte_en) begin
            word_out[{r_idx, 3'b000} +: 8] = byte_in;
        end
    end

    assign word_last = byte_en && (&r_idx);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (byte_en) begin
            r_idx  <= r_idx + 1'b1;
            r_word <= word_out;
        end
    end

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Boot loader streaming a length-prefixed image into imem.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_reset,
    output logic                  done,
    output logic                  overflow,
    output logic [15:0]           words_loaded
);

    localparam logic [16:0] c_depth = 17'(2 ** ADDR_WIDTH);

    state_t                r_state;
    state_t                w_next;
    logic [15:0]           r_count;
    logic [15:0]           r_words;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic                  r_overflow;

    logic                  w_accept;
    logic                  w_byte_en;
    logic                  w_clear;
    logic [15:0]           w_full_count;
    logic [31:0]           w_word;
    logic                  w_word_last;
    logic                  w_in_range;
    logic                  w_last_word;

    assign w_accept     = in_valid && in_ready;
    assign w_byte_en    = w_accept && (r_state == ST_DATA);
    assign w_clear      = (r_state != ST_DATA);
    assign w_full_count = {in_data, r_count[7:0]};
    assign w_in_range   = ({1'b0, r_words} < c_depth);
    assign w_last_word  = (r_words == (r_count - 16'd1));

    word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_clear),
        .byte_en   (w_byte_en),
        .byte_in   (in_data),
        .word_out  (w_word),
        .word_last (w_word_last)
    );

    always_comb begin
        w_next     = r_state;
        in_ready   = 1'b0;
        core_reset = 1'b1;
        done       = 1'b0;
        case (r_state)
            ST_LEN0: begin
                in_ready = 1'b1;
                if (w_accept) w_next = ST_LEN1;
            end
            ST_LEN1: begin
                in_ready = 1'b1;
                if (w_accept) w_next = (w_full_count == 16'd0) ? ST_DONE : ST_DATA;
            end
            ST_DATA: begin
                in_ready = 1'b1;
                if (w_word_last && w_last_word) w_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                w_next = ST_DONE;
            end
            ST_DONE: begin
                core_reset = 1'b0;
                done       = 1'b1;
            end
            default: begin
                w_next = ST_LEN0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_LEN0;
            r_count     <= '0;
            r_words     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_mem_we <= 1'b0;
            if (w_accept && r_state == ST_LEN0) begin
                r_count[7:0] <= in_data;
            end
            if (w_accept && r_state == ST_LEN1) begin
                r_count[15:8] <= in_data;
                if ({1'b0, w_full_count} > c_depth) r_overflow <= 1'b1;
            end
            // Words past the memory depth are counted but never written
            if (w_word_last) begin
                r_mem_wdata <= w_word;
                r_mem_addr  <= r_words[ADDR_WIDTH-1:0];
                r_mem_we    <= w_in_range;
                r_words     <= r_words + 16'd1;
            end
        end
    end

    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign overflow     = r_overflow;
    assign words_loaded = r_words;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Directed bench for prog_loader at ADDR_WIDTH 8 and 2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset    = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;

    logic        in_ready_a, mem_we_a, core_reset_a, done_a, overflow_a;
    logic [7:0]  mem_addr_a;
    logic [31:0] mem_wdata_a;
    logic [15:0] words_loaded_a;

    logic        in_ready_b, mem_we_b, core_reset_b, done_b, overflow_b;
    logic [1:0]  mem_addr_b;
    logic [31:0] mem_wdata_b;
    logic [15:0] words_loaded_b;

    prog_loader #(.ADDR_WIDTH(8)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .core_reset(core_reset_a), .done(done_a),
        .overflow(overflow_a), .words_loaded(words_loaded_a)
    );

    prog_loader #(.ADDR_WIDTH(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .core_reset(core_reset_b), .done(done_b),
        .overflow(overflow_b), .words_loaded(words_loaded_b)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  qa_addr[$];
    logic [31:0] qa_data[$];
    logic [1:0]  qb_addr[$];
    logic [31:0] qb_data[$];

    logic [7:0] img [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                             8'h93, 8'h05, 8'hB0, 8'h00};

    always @(negedge clk) begin
        if (mem_we_a) begin
            qa_addr.push_back(mem_addr_a);
            qa_data.push_back(mem_wdata_a);
        end
        if (mem_we_b) begin
            qb_addr.push_back(mem_addr_b);
            qb_data.push_back(mem_wdata_b);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready_a) begin
                in_valid = 1'b1;
                in_data  = b;
                @(posedge clk);
                #1 in_valid = 1'b0;
                ok = 1'b1;
            end
        end
        check("send_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        qa_addr.delete(); qa_data.delete();
        qb_addr.delete(); qb_data.delete();
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_in_ready", in_ready_a, 1);
        check("rst_mem_we", mem_we_a, 0);
        check("rst_mem_addr", mem_addr_a, 0);
        check("rst_mem_wdata", mem_wdata_a, 0);
        check("rst_core_reset", core_reset_a, 1);
        check("rst_done", done_a, 0);
        check("rst_overflow", overflow_a, 0);
        check("rst_words", words_loaded_a, 0);

        // Two-word image, one byte per cycle
        for (int i = 0; i < 6; i++) send(img[i]);
        @(negedge clk);
        check("w0_we", mem_we_a, 1);
        check("w0_addr", mem_addr_a, 0);
        check("w0_data", mem_wdata_a, 32'h00A00513);
        check("w0_words", words_loaded_a, 1);
        check("w0_ready", in_ready_a, 1);
        for (int i = 6; i < 10; i++) send(img[i]);
        @(negedge clk);
        check("w1_we", mem_we_a, 1);
        check("w1_addr", mem_addr_a, 1);
        check("w1_data", mem_wdata_a, 32'h00B00593);
        check("flush_ready", in_ready_a, 0);
        check("flush_done", done_a, 0);
        check("flush_core_reset", core_reset_a, 1);
        @(negedge clk);
        check("fin_done", done_a, 1);
        check("fin_core_reset", core_reset_a, 0);
        check("fin_we", mem_we_a, 0);
        check("fin_words", words_loaded_a, 2);
        #2 check("fin_nwrites", qa_addr.size(), 2);

        // Zero-length header
        do_reset();
        send(8'h00);
        send(8'h00);
        @(negedge clk);
        check("z_done", done_a, 1);
        check("z_core_reset", core_reset_a, 0);
        check("z_ready", in_ready_a, 0);
        repeat (3) @(negedge clk);
        #2;
        check("z_nwrites", qa_addr.size(), 0);
        check("z_ready_later", in_ready_a, 0);

        // Same image with in_valid toggling
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(img[i]);
            @(negedge clk);
            check("tog_we", mem_we_a, (i == 5 || i == 9) ? 1 : 0);
            if (i >= 2 && i <= 8) check("tog_ready", in_ready_a, 1);
        end
        @(negedge clk);
        check("tog_done", done_a, 1);
        #2;
        check("tog_nwrites", qa_addr.size(), 2);
        check("tog_addr1", qa_addr[1], 1);
        check("tog_data0", qa_data[0], 32'h00A00513);
        check("tog_data1", qa_data[1], 32'h00B00593);

        // Five words into a four-word memory (dut_b) and a 256-word memory (dut_a)
        do_reset();
        send(8'h05);
        send(8'h00);
        for (int j = 0; j < 20; j++) send(8'(j + 1));
        @(negedge clk);
        check("ovf_we_b", mem_we_b, 0);
        check("ovf_we_a", mem_we_a, 1);
        check("ovf_addr_a", mem_addr_a, 4);
        check("ovf_ready_b", in_ready_b, 0);
        @(negedge clk);
        check("ovf_done_b", done_b, 1);
        check("ovf_flag_b", overflow_b, 1);
        check("ovf_flag_a", overflow_a, 0);
        check("ovf_words_b", words_loaded_b, 5);
        #2;
        check("ovf_nwrites_b", qb_addr.size(), 4);
        check("ovf_addr3_b", qb_addr[3], 3);
        check("ovf_data3_b", qb_data[3], 32'h100F0E0D);
        check("ovf_nwrites_a", qa_addr.size(), 5);
        check("ovf_data4_a", qa_data[4], 32'h14131211);

        // Reset in the middle of the second word
        do_reset();
        for (int i = 0; i < 8; i++) send(img[i]);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_we", mem_we_a, 0);
        check("mid_core_reset", core_reset_a, 1);
        check("mid_words", words_loaded_a, 0);
        check("mid_ready", in_ready_a, 1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check("mid_nwrites", qa_addr.size(), 1);
        check("mid_addr0", qa_addr[0], 0);
        for (int i = 0; i < 10; i++) send(img[i]);
        repeat (2) @(negedge clk);
        check("reload_done", done_a, 1);
        check("reload_words", words_loaded_a, 2);
        #2;
        check("reload_nwrites", qa_addr.size(), 3);
        check("reload_data", qa_data[2], 32'h00B00593);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
